eight_bit_four_to_one_merge_module: RTL and testbench
=====================================================

# eight_bit_four_to_one_merge_module

Merges four 8-bit source streams into one 8-bit output stream with valid/ready handshakes. It is the collecting end of the 1-to-4 demux fan-out: data that was steered by a 2-bit select onto four lanes is gathered back onto a single lane. The 2-bit source index is regenerated alongside each byte, so a downstream demux can route it back out. A round-robin arbiter picks the source, and a one-entry output register drives the output.

## Interface
- No parameters. Data width is fixed at 8 bits and there are fixed at 4 sources.
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- a1, a2, a3, a4  input  8 each  source data bytes
- v1, v2, v3, v4  input  1 each  source valid
- r1, r2, r3, r4  output  1 each  source ready (combinational)
- out  output  8  merged data byte
- s  output  2  source index of `out` (0 = a1 … 3 = a4); uses the demux select encoding
- out_valid  output  1  `out` and `s` hold a valid beat
- out_ready  input  1  sink accepts the beat

## Operation
- Handshakes:
  - Source transfer on input i: vi and ri are both high at a rising edge.
  - Output transfer: out_valid and out_ready are both high at a rising edge.
- load_en = ~out_valid | out_ready. The output register can take a new beat only when load_en is high.
- Arbiter:
  - 2-bit pointer `ptr`; its reset value is 0.
  - Candidate order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - grant = the first candidate with vi high.
- ri = load_en & grant==i & ~reset. At most one ri is high per cycle. No ri is high when no vi is high.
- On a source transfer from source i:
  - out <= ai, s <= i, out_valid <= 1.
  - ptr <= i+1 (mod 4). Source 3 wraps the pointer to 0.
- Output transfer with no source transfer in the same cycle: out_valid <= 0. out and s hold their last values.
- Output transfer and source transfer in the same cycle: the register is replaced by the new beat and out_valid stays 1. This gives full throughput of one beat per cycle.
- out_valid high with out_ready low:
  - out, s, out_valid and ptr all hold.
  - All ri are low.
  - Sources are never dropped. A source whose vi is high keeps it until it is granted.
- No valid source and load_en high: out_valid <= 0 and ptr holds.
- Reset (evaluated at the edge):
  - out = 8'h00, s = 2'b00, out_valid = 0, ptr = 0.
  - All ri are forced to 0 while reset is high.
- Reset mid-operation: a held beat is discarded without an output transfer. Any input that was offered during the reset cycle is not consumed.
- Data is passed through unmodified. No arithmetic is applied to the payload.

## Timing
- Latency: a source transfer at edge N gives out_valid = 1 with that beat from edge N up to and including the edge of its output transfer.
- ri depends combinationally on v1–v4, out_valid, out_ready, ptr and reset.
- No path from ai to any output is combinational. out and s are registered.
- Sustained throughput is 1 beat/cycle when out_ready is held high.
- Fairness: with all four vi held high, grants rotate 0,1,2,3,0,… Any continuously valid source is granted within 4 output transfers.

## Configuration
- ROUND_ROBIN_EN
  - Defined: arbitration is the rotating-pointer scheme above.
  - Not defined: fixed priority. Grant goes to the lowest-index valid source (a1 highest). ptr is not implemented and is not updated. All other behaviour is unchanged.
- The build default is ROUND_ROBIN_EN defined.

## Test plan
- Reset check: hold reset for 2 cycles with v1–v4 = 1 and out_ready = 1.
  - r1–r4 = 0 throughout.
  - After reset: out = 8'h00, s = 0, out_valid = 0.
- Single source: only v3 = 1, a3 = 8'hA5, out_ready = 1.
  - One edge later: out = 8'hA5, s = 2, out_valid = 1.
  - r3 stays high every cycle, one beat per cycle.
- Rotation (ROUND_ROBIN_EN): all vi = 1, with a1..a4 = 8'h11, 22, 33, 44 and out_ready = 1.
  - out sequence is 11, 22, 33, 44, 11 and s sequence is 0, 1, 2, 3, 0.
  - Without the macro, out = 8'h11 every cycle.
- Backpressure: beat held while out_ready = 0 for 3 cycles, with v2 = 1.
  - out, s and out_valid are stable.
  - r2 = 0 throughout.
  - The beat transfers on the first cycle out_ready = 1, and a2 is accepted on that same edge.
- Wrap and idle: grant source 3, then drop all vi.
  - out_valid goes to 0 after the output transfer.
  - The next lone v1 is granted, showing ptr wrapped to 0.
- Mid-operation reset: assert reset while out_valid = 1 and out_ready = 0.
  - Next edge: out_valid = 0, s = 0, out = 8'h00.
  - After reset, source 1 (a1) wins first.

Source files
------------

// File: rtl/eight_bit_four_to_one_merge_module.sv
// eight_bit_four_to_one_merge_module
// Gathers four 8-bit valid/ready source streams back onto a single output
// lane. Each output beat also carries the 2-bit index of the source it came
// from, so a downstream 1-to-4 demux can route it back out. A one-entry
// output register decouples the sink from the sources.
//
// Configuration macro: ROUND_ROBIN_EN
//   defined     : rotating-pointer round-robin arbitration (production setting)
//   not defined : fixed priority, a1 highest; no pointer state exists
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   a1..a4       source data bytes
//   v1..v4       source valid
//   r1..r4       source ready (combinational from v*, out_valid, out_ready,
//                pointer and reset)
//   out          registered merged data byte
//   s            registered source index of out (0 = a1 .. 3 = a4)
//   out_valid    out/s hold a valid beat
//   out_ready    sink accepts the beat
module eight_bit_four_to_one_merge_module (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a1,
  input  logic [7:0] a2,
  input  logic [7:0] a3,
  input  logic [7:0] a4,
  input  logic       v1,
  input  logic       v2,
  input  logic       v3,
  input  logic       v4,
  output logic       r1,
  output logic       r2,
  output logic       r3,
  output logic       r4,
  output logic [7:0] out,
  output logic [1:0] s,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SRC_N  = 4;
  localparam int unsigned IDX_W  = 2;

  logic [SRC_N-1:0]  valid_vec;
  logic [SRC_N-1:0]  ready_vec;
  logic              load_en;
  logic              any_valid;
  logic              take;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  cand;
  logic [DATA_W-1:0] grant_data;

`ifdef ROUND_ROBIN_EN
  // Index of the highest-priority candidate for the next grant.
  logic [IDX_W-1:0]  ptr;
`endif

  assign valid_vec = {v4, v3, v2, v1};

  // Output register can accept a new beat when empty or draining this edge.
  assign load_en = ~out_valid | out_ready;

  // Arbiter: walk candidates from lowest to highest priority so the last hit
  // (the highest-priority valid source) is the one that sticks.
  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int k = SRC_N - 1; k >= 0; k--) begin
`ifdef ROUND_ROBIN_EN
      cand = IDX_W'(ptr + IDX_W'(k));
`else
      cand = IDX_W'(k);
`endif
      if (valid_vec[cand]) begin
        grant     = cand;
        any_valid = 1'b1;
      end
    end
  end

  // A source transfer happens whenever the granted source is offered a slot.
  assign take = any_valid & load_en & ~reset;

  // One-hot ready towards the granted source only.
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < SRC_N; i++) begin
      ready_vec[i] = take & (grant == IDX_W'(i));
    end
  end

  assign r1 = ready_vec[0];
  assign r2 = ready_vec[1];
  assign r3 = ready_vec[2];
  assign r4 = ready_vec[3];

  // Data mux for the granted source.
  always_comb begin
    grant_data = a1;
    case (grant)
      2'd0:    grant_data = a1;
      2'd1:    grant_data = a2;
      2'd2:    grant_data = a3;
      default: grant_data = a4;
    endcase
  end

  // Output register; out and s keep their last values when the beat drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      s         <= '0;
      out_valid <= 1'b0;
    end else if (take) begin
      out       <= grant_data;
      s         <= grant;
      out_valid <= 1'b1;
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ROUND_ROBIN_EN
  // Pointer moves just past the winner; 2-bit arithmetic wraps 3 -> 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= IDX_W'(grant + IDX_W'(1));
    end
  end
`endif

endmodule

// File: tb/tb_eight_bit_four_to_one_merge_module.sv
// Self-checking bench for eight_bit_four_to_one_merge_module: directed test
// plan sequences followed by randomized traffic, all against a reference
// model of the merge behaviour.
module tb_eight_bit_four_to_one_merge_module;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_in [4];
  logic [3:0] v_in;
  logic [3:0] r_out;
  logic [7:0] out;
  logic [1:0] s;
  logic       out_valid;
  logic       out_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_ptr = 0;
  logic [7:0] m_out = 8'h00;
  int         m_s   = 0;
  bit         m_ov  = 1'b0;
  int         last_g = -1;

  always #5 clk = ~clk;

  eight_bit_four_to_one_merge_module dut (
    .clk       (clk),
    .reset     (reset),
    .a1        (a_in[0]),
    .a2        (a_in[1]),
    .a3        (a_in[2]),
    .a4        (a_in[3]),
    .v1        (v_in[0]),
    .v2        (v_in[1]),
    .v3        (v_in[2]),
    .v4        (v_in[3]),
    .r1        (r_out[0]),
    .r2        (r_out[1]),
    .r3        (r_out[2]),
    .r4        (r_out[3]),
    .out       (out),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Which source should win given the current offers; -1 when none.
  function automatic int model_grant();
`ifdef ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      if (v_in[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (v_in[k]) return k;
    end
`endif
    return -1;
  endfunction

  // Called just after a falling edge with inputs already driven: checks the
  // ready outputs, steps one clock, then checks the registered outputs.
  task automatic cycle();
    int  g;
    bit  load;
    bit  take;
    #1;
    g    = model_grant();
    load = !m_ov || out_ready;
    take = !reset && load && (g >= 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("r%0d", i + 1), 32'(r_out[i]), 32'(take && (g == i)));
    end
    @(posedge clk);
    last_g = -1;
    if (reset) begin
      m_out = 8'h00; m_s = 0; m_ov = 1'b0; m_ptr = 0;
    end else if (take) begin
      m_out  = a_in[g];
      m_s    = g;
      m_ov   = 1'b1;
      m_ptr  = (g + 1) % 4;
      last_g = g;
    end else if (load) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
    check("out", 32'(out), 32'(m_out));
    check("s", 32'(s), 32'(m_s));
    check("out_valid", 32'(out_valid), 32'(m_ov));
  endtask

  task automatic set_src(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
    v_in = v;
    a_in[0] = d0; a_in[1] = d1; a_in[2] = d2; a_in[3] = d3;
  endtask

  logic [7:0] rot_exp [5];
  logic [7:0] held_out;

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    set_src(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);

    // Reset held two cycles with every source offering
    cycle();
    cycle();
    reset = 1'b0;
    set_src(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    check("rst_out", 32'(out), 32'h00);
    check("rst_s", 32'(s), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);

    // Single source: only a3
    set_src(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
    cycle();
    check("single_out", 32'(out), 32'hA5);
    check("single_s", 32'(s), 32'h2);
    check("single_valid", 32'(out_valid), 32'h1);
    cycle();
    cycle();

    // Rotation from a freshly reset pointer
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_src(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
`ifdef ROUND_ROBIN_EN
    rot_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`else
    rot_exp = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`endif
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("rot%0d", i), 32'(out), 32'(rot_exp[i]));
    end

    // Backpressure with v2 waiting
    set_src(4'b0010, 8'h00, 8'h5A, 8'h00, 8'h00);
    out_ready = 1'b0;
    held_out = out;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_hold", 32'(out), 32'(held_out));
      check("bp_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_release_out", 32'(out), 32'h5A);
    check("bp_release_s", 32'(s), 32'h1);

    // Wrap and idle: grant source 3, drain, then v1 and v2 compete
    set_src(4'b1000, 8'h00, 8'h00, 8'h00, 8'h77);
    cycle();
    check("wrap_s", 32'(s), 32'h3);
    set_src(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    cycle();
    check("idle_valid", 32'(out_valid), 32'h0);
    set_src(4'b0011, 8'hC1, 8'hC2, 8'h00, 8'h00);
    cycle();
    check("wrap_next_s", 32'(s), 32'h0);
    check("wrap_next_out", 32'(out), 32'hC1);

    // Mid-operation reset while a beat is held
    set_src(4'b0100, 8'h00, 8'h00, 8'h3C, 8'h00);
    cycle();
    out_ready = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_out", 32'(out), 32'h00);
    check("mid_rst_s", 32'(s), 32'h0);
    reset = 1'b0;
    out_ready = 1'b1;
    set_src(4'b1111, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
    cycle();
    check("post_rst_s", 32'(s), 32'h0);

    // Randomized traffic; offered sources keep their data until granted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (v_in[i] && last_g == i) begin
          v_in[i] = 1'($urandom_range(0, 1));
          a_in[i] = 8'($urandom);
        end else if (!v_in[i]) begin
          v_in[i] = ($urandom_range(0, 2) == 0);
          a_in[i] = 8'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
